mem_slot_arbiter: RTL and testbench

- Time-division arbiter for the single shared memory port (frame buffer SRAM plus glyph ROM).
- Generates the 3-bit slot counter `acnt` consumed by the VGA controller and reserves slots 0/1 for VGA fetches.
- Shares slots 2..7 between a CPU port and a DMA port using a req/ack handshake and round-robin priority.
- Registers returned read data back to each requester.

---
 rtl/mem_slot_arbiter_pkg.sv | 9 +
 rtl/mem_slot_arbiter_rr_grant2.sv | 22 ++
 rtl/mem_slot_arbiter.sv | 85 ++++++++
 tb/tb_mem_slot_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_slot_arbiter_pkg.sv
// mem_slot_arbiter_pkg: shared widths, slot numbers and requester ids for the memory slot arbiter.
package mem_slot_arbiter_pkg;
  localparam int DATAWIDTH = 16;
  localparam int ADDRWIDTH = 16;
  localparam logic [2:0] SLOT_VGA_FB = 3'd0;
  localparam logic [2:0] SLOT_VGA_GL = 3'd1;
  localparam logic [2:0] SLOT_LAST = 3'd7;
  typedef enum logic {REQ_CPU = 1'b0, REQ_DMA = 1'b1} req_id_e;
endpackage

// File: rtl/mem_slot_arbiter_rr_grant2.sv
// rr_grant2: two-requester round-robin grant, masking requesters still finishing their previous access.
module rr_grant2
  import mem_slot_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] pending,
  input  logic       enable,
  output logic [1:0] grant
);
  req_id_e ptr;
  logic [1:0] elig;
  always_comb begin
    elig = enable ? (req & ~pending) : 2'b00;
    grant = (&elig) ? ((ptr == REQ_CPU) ? 2'b01 : 2'b10) : elig;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= REQ_CPU;
    else if (grant[0]) ptr <= REQ_DMA;
    else if (grant[1]) ptr <= REQ_CPU;
endmodule

// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: TDM arbiter of the shared memory port; slots 0/1 feed VGA, slots 2..7 serve CPU/DMA.
// ARB_BLANK_RELEASE_EN: when defined, slots 0/1 are also arbitrated while vga_active is low.
module mem_slot_arbiter #(
  parameter int DATAWIDTH = mem_slot_arbiter_pkg::DATAWIDTH,
  parameter int ADDRWIDTH = mem_slot_arbiter_pkg::ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRWIDTH-1:0] vga_addr,
  input  logic                 vga_active,
  output logic [DATAWIDTH-1:0] glyph_num,
  output logic [DATAWIDTH-1:0] glyph_pixels,
  output logic [2:0]           acnt,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDRWIDTH-1:0] cpu_addr,
  input  logic [DATAWIDTH-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [DATAWIDTH-1:0] cpu_rdata,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [ADDRWIDTH-1:0] dma_addr,
  input  logic [DATAWIDTH-1:0] dma_wdata,
  output logic                 dma_ack,
  output logic [DATAWIDTH-1:0] dma_rdata,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata
);
  import mem_slot_arbiter_pkg::*;
  logic vga_slot;
  logic [1:0] grant, pend, rd_pend;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] wdata_q, gn_q, gp_q, cpu_rd_q, dma_rd_q;
`ifdef ARB_BLANK_RELEASE_EN
  assign vga_slot = (acnt <= SLOT_VGA_GL) && vga_active;
`else
  logic unused_vga_active;
  assign unused_vga_active = vga_active;
  assign vga_slot = acnt <= SLOT_VGA_GL;
`endif
  rr_grant2 u_rr (
    .clk(clk),
    .rst(rst),
    .req({dma_req, cpu_req}),
    .pending(pend),
    .enable(~vga_slot),
    .grant(grant)
  );
  // Idle slots keep the last address on the bus; reset forces the bus to zero.
  always_comb begin
    mem_addr = rst ? '0 : grant[1] ? dma_addr : grant[0] ? cpu_addr : vga_slot ? vga_addr : addr_q;
    mem_we = !rst && (grant[1] ? dma_we : (grant[0] && cpu_we));
    mem_wdata = rst ? '0 : grant[1] ? dma_wdata : grant[0] ? cpu_wdata : wdata_q;
    glyph_num = (acnt == SLOT_VGA_GL) ? mem_rdata : gn_q;
    glyph_pixels = (acnt == SLOT_VGA_GL + 3'd1) ? mem_rdata : gp_q;
    cpu_ack = pend[0];
    dma_ack = pend[1];
    cpu_rdata = rd_pend[0] ? mem_rdata : cpu_rd_q;
    dma_rdata = rd_pend[1] ? mem_rdata : dma_rd_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acnt <= SLOT_VGA_FB;
      pend <= '0;
      rd_pend <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      gn_q <= '0;
      gp_q <= '0;
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
    end else begin
      acnt <= (acnt == SLOT_LAST) ? SLOT_VGA_FB : acnt + 3'd1;
      pend <= grant;
      rd_pend <= grant & ~{dma_we, cpu_we};
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
      if (acnt == SLOT_VGA_GL) gn_q <= mem_rdata;
      if (acnt == SLOT_VGA_GL + 3'd1) gp_q <= mem_rdata;
      if (rd_pend[0]) cpu_rd_q <= mem_rdata;
      if (rd_pend[1]) dma_rd_q <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_slot_arbiter.sv
// tb_mem_slot_arbiter: random CPU/DMA traffic against a slot-level reference model of the arbiter.
module tb_mem_slot_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] vga_addr = '0, glyph_num, glyph_pixels;
  logic vga_active = 1'b1;
  logic [2:0] acnt;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic cpu_ack, dma_ack, mem_we;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_slot_arbiter dut (
    .clk(clk), .rst(rst), .vga_addr(vga_addr), .vga_active(vga_active),
    .glyph_num(glyph_num), .glyph_pixels(glyph_pixels), .acnt(acnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference model: which requester owns each slot, what the memory holds, what each output should show.
  int slot, win;
  bit ptr;
  bit pend [2], rdp [2], fr [2];
  logic rq [2], wv [2];
  logic [15:0] av [2], dv [2], rd_exp [2];
  logic [15:0] last_addr, ret, gn, gp, exp_addr;
  bit vs, exp_we, el0, el1;
  task automatic model_reset();
    slot = 0; ptr = 0; last_addr = '0; gn = '0; gp = '0; ret = ref_mem[0];
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; rdp[p] = 0; fr[p] = 0; rq[p] = 0; rd_exp[p] = '0;
    end
  endtask
  task automatic check_reset();
    check("rst_acnt", acnt, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dma_ack", dma_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_glyph_num", glyph_num, 0);
    check("rst_glyph_pixels", glyph_pixels, 0);
  endtask
  task automatic drive();
    for (int p = 0; p < 2; p++)
      if (!rq[p] || fr[p]) begin
        rq[p] = ($urandom % 4) != 0;
        wv[p] = $urandom % 2;
        av[p] = 16'($urandom % 64);
        dv[p] = 16'($urandom);
        fr[p] = 0;
      end
    cpu_req = rq[0]; cpu_we = wv[0]; cpu_addr = av[0]; cpu_wdata = dv[0];
    dma_req = rq[1]; dma_we = wv[1]; dma_addr = av[1]; dma_wdata = dv[1];
    vga_addr = 16'($urandom % 64);
    vga_active = $urandom % 2;
  endtask
  task automatic model_check();
    check("acnt", acnt, slot);
    check("cpu_ack", cpu_ack, pend[0]);
    check("dma_ack", dma_ack, pend[1]);
    if (rdp[0]) rd_exp[0] = ret;
    if (rdp[1]) rd_exp[1] = ret;
    check("cpu_rdata", cpu_rdata, rd_exp[0]);
    check("dma_rdata", dma_rdata, rd_exp[1]);
    if (slot == 1) gn = ret;
    if (slot == 2) gp = ret;
    check("glyph_num", glyph_num, gn);
    check("glyph_pixels", glyph_pixels, gp);
`ifdef ARB_BLANK_RELEASE_EN
    vs = slot < 2 && vga_active;
`else
    vs = slot < 2;
`endif
    el0 = !vs && rq[0] && !pend[0];
    el1 = !vs && rq[1] && !pend[1];
    win = (el0 && el1) ? int'(ptr) : el0 ? 0 : el1 ? 1 : -1;
    exp_addr = vs ? vga_addr : (win >= 0) ? av[win] : last_addr;
    exp_we = (win >= 0) && wv[win];
    check("mem_addr", mem_addr, exp_addr);
    check("mem_we", mem_we, exp_we);
    if (exp_we) check("mem_wdata", mem_wdata, dv[win]);
    for (int p = 0; p < 2; p++) begin
      if (pend[p]) fr[p] = 1;
      pend[p] = (win == p);
      rdp[p] = (win == p) && !wv[p];
    end
    ret = ref_mem[exp_addr];
    if (exp_we) ref_mem[exp_addr] = dv[win];
    if (win >= 0) ptr = (win == 0);
    last_addr = exp_addr;
    slot = (slot + 1) % 8;
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i * 40503 + 1234);
      ref_mem[i] = mem[i];
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      if (cyc == 0 || cyc == 1501 || cyc == 2702) begin
        #1 rst = 1'b1;
        #2 check_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
      end else #1;
      drive();
      @(negedge clk);
      model_check();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
